// File: rtl/cpu_types_pkg.sv
// Shared CPU types: datapath widths and the writeback state encoding
// used by the writeback unit, the hazard unit and the benches.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    HALTED    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/writeback_unit.sv
// Register-file write port driver: registers ALU/load results, parks a missed
// load until the data cache hits, exports load-use hazard flags and latches halt.
module writeback_unit #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nrst,
  input  logic              mem_valid,
  input  logic              mem_regwrite,
  input  logic              mem_is_load,
  input  logic              mem_halt,
  input  logic [REG_W-1:0]  mem_wsel,
  input  logic [WORD_W-1:0] mem_result,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              dhit,
  output logic              wb_ready,
  output logic              WEN,
  output logic [REG_W-1:0]  wsel,
  output logic [WORD_W-1:0] wdat,
  input  logic [REG_W-1:0]  rsel1,
  input  logic [REG_W-1:0]  rsel2,
  output logic              pend_hit1,
  output logic              pend_hit2,
  output logic              halted
);

  import cpu_types_pkg::*;

  wb_state_t         state, state_n;
  logic [REG_W-1:0]  pend_sel, pend_sel_n;
  logic              pend_we, pend_we_n;
  logic              wen_n;
  logic [REG_W-1:0]  wsel_n;
  logic [WORD_W-1:0] wdat_n;
  logic              pend_live;

  always_ff @(posedge CLK) begin
    if (!nrst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (mem_valid) begin
          if (mem_is_load && !dhit) state_n = LOAD_WAIT;
          else if (mem_halt)        state_n = HALTED;
        end
      end
      LOAD_WAIT: if (dhit) state_n = IDLE;
      HALTED:    state_n = HALTED;
      default:   state_n = IDLE;
    endcase
  end

  // Next write-port / pending values plus the state-decoded flags.
  always_comb begin
    wen_n      = 1'b0;
    wsel_n     = wsel;
    wdat_n     = wdat;
    pend_sel_n = pend_sel;
    pend_we_n  = pend_we;
    wb_ready   = 1'b0;
    halted     = 1'b0;
    pend_hit1  = 1'b0;
    pend_hit2  = 1'b0;
    pend_live  = pend_we && (pend_sel != '0);
    case (state)
      IDLE: begin
        wb_ready = 1'b1;
        if (mem_valid) begin
          if (mem_is_load && !dhit) begin
            pend_sel_n = mem_wsel;
            pend_we_n  = mem_regwrite;
          end else begin
            wen_n  = mem_regwrite && (mem_wsel != '0);
            wsel_n = mem_wsel;
            wdat_n = mem_is_load ? dmemload : mem_result;
          end
        end
      end
      LOAD_WAIT: begin
        pend_hit1 = pend_live && (rsel1 == pend_sel);
        pend_hit2 = pend_live && (rsel2 == pend_sel);
        if (dhit) begin
          wen_n  = pend_live;
          wsel_n = pend_sel;
          wdat_n = dmemload;
        end
      end
      HALTED:  halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nrst) begin
      WEN      <= 1'b0;
      wsel     <= '0;
      wdat     <= '0;
      pend_sel <= '0;
      pend_we  <= 1'b0;
    end else begin
      WEN      <= wen_n;
      wsel     <= wsel_n;
      wdat     <= wdat_n;
      pend_sel <= pend_sel_n;
      pend_we  <= pend_we_n;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed cycle table from the test plan, then
// randomized traffic checked against a transaction-level reference model.
module tb_writeback_unit;

  logic        CLK = 1'b0;
  logic        nrst;
  logic        mem_valid, mem_regwrite, mem_is_load, mem_halt;
  logic [4:0]  mem_wsel;
  logic [31:0] mem_result, dmemload;
  logic        dhit;
  logic        wb_ready, WEN;
  logic [4:0]  wsel;
  logic [31:0] wdat;
  logic [4:0]  rsel1, rsel2;
  logic        pend_hit1, pend_hit2, halted;

  int total = 0;
  int bad   = 0;

  writeback_unit #(.WORD_W(32), .REG_W(5)) dut (
    .CLK(CLK), .nrst(nrst), .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
    .mem_is_load(mem_is_load), .mem_halt(mem_halt), .mem_wsel(mem_wsel),
    .mem_result(mem_result), .dmemload(dmemload), .dhit(dhit), .wb_ready(wb_ready),
    .WEN(WEN), .wsel(wsel), .wdat(wdat), .rsel1(rsel1), .rsel2(rsel2),
    .pend_hit1(pend_hit1), .pend_hit2(pend_hit2), .halted(halted)
  );

  always #5 CLK = ~CLK;

  // One cycle of stimulus; pre-edge flags checked with these inputs,
  // write port checked after the edge.
  typedef struct {
    bit          nrst, valid, rw, load, halt;
    logic [4:0]  sel;
    logic [31:0] result, dmem;
    bit          dhit;
    logic [4:0]  r1, r2;
    bit          chk_pre, e_ready, e_halted, e_ph1, e_ph2;
    bit          e_wen;
    logic [4:0]  e_wsel;
    logic [31:0] e_wdat;
    bit          chk_data;
  } vec_t;

  localparam int unsigned NVEC = 19;
  vec_t tbl [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an outstanding-load record, a halt flag and the last write.
  bit          m_init, m_wait, m_halt, m_pwe, m_fresh;
  logic [4:0]  m_psel;
  bit          m_wen;
  logic [4:0]  m_wsel;
  logic [31:0] m_wdat;

  task automatic model_edge();
    if (!nrst) begin
      m_init = 1; m_wait = 0; m_halt = 0; m_pwe = 0; m_psel = '0;
      m_wen = 0; m_wsel = '0; m_wdat = '0; m_fresh = 1;
      return;
    end
    m_fresh = 0;
    m_wen = 0;
    if (m_halt) return;
    if (m_wait) begin
      if (dhit) begin
        m_wait = 0;
        m_wen  = m_pwe && (m_psel != 0);
        m_wsel = m_psel;
        m_wdat = dmemload;
      end
    end else if (mem_valid) begin
      if (mem_is_load && !dhit) begin
        m_wait = 1; m_psel = mem_wsel; m_pwe = mem_regwrite;
      end else begin
        m_wen  = mem_regwrite && (mem_wsel != 0);
        m_wsel = mem_wsel;
        m_wdat = mem_is_load ? dmemload : mem_result;
        if (mem_halt) m_halt = 1;
      end
    end
  endtask

  task automatic check_model_pre(input int c);
    chk($sformatf("rnd%0d wb_ready", c), 32'(wb_ready), 32'(!m_wait && !m_halt));
    chk($sformatf("rnd%0d halted", c), 32'(halted), 32'(m_halt));
    chk($sformatf("rnd%0d pend_hit1", c), 32'(pend_hit1),
        32'(m_wait && m_pwe && m_psel != 0 && rsel1 == m_psel));
    chk($sformatf("rnd%0d pend_hit2", c), 32'(pend_hit2),
        32'(m_wait && m_pwe && m_psel != 0 && rsel2 == m_psel));
  endtask

  task automatic check_model_post(input int c);
    chk($sformatf("rnd%0d WEN", c), 32'(WEN), 32'(m_wen));
    if (m_wen || m_fresh) begin
      chk($sformatf("rnd%0d wsel", c), 32'(wsel), 32'(m_wsel));
      chk($sformatf("rnd%0d wdat", c), wdat, m_wdat);
    end
  endtask

  initial begin
    vec_t v;
    //        nrst vld rw  ld  hlt sel    result        dmem          dhit r1     r2     pre rdy hlt ph1 ph2 wen wsel   wdat          data
    tbl[0]  = '{'0, '0, '0, '0, '0, 5'd0,  32'h0,        32'h0,        '0, 5'd0,  5'd0,  '0, '0, '0, '0, '0, '0, 5'd0,  32'h0,        '1};
    tbl[1]  = '{'1, '1, '1, '0, '0, 5'd5,  32'hDEADBEEF, 32'h0,        '0, 5'd0,  5'd0,  '1, '1, '0, '0, '0, '1, 5'd5,  32'hDEADBEEF, '0};
    tbl[2]  = '{'1, '0, '0, '0, '0, 5'd0,  32'h0,        32'h0,        '0, 5'd0,  5'd0,  '1, '1, '0, '0, '0, '0, 5'd0,  32'h0,        '0};
    tbl[3]  = '{'1, '1, '1, '0, '0, 5'd0,  32'h55,       32'h0,        '0, 5'd0,  5'd0,  '1, '1, '0, '0, '0, '0, 5'd0,  32'h0,        '0};
    tbl[4]  = '{'1, '0, '0, '0, '0, 5'd0,  32'h0,        32'h0,        '0, 5'd0,  5'd0,  '1, '1, '0, '0, '0, '0, 5'd0,  32'h0,        '0};
    tbl[5]  = '{'1, '1, '1, '1, '0, 5'd9,  32'h0,        32'h0,        '0, 5'd9,  5'd8,  '1, '1, '0, '0, '0, '0, 5'd0,  32'h0,        '0};
    tbl[6]  = '{'1, '1, '1, '1, '0, 5'd9,  32'h0,        32'h0,        '0, 5'd9,  5'd8,  '1, '0, '0, '1, '0, '0, 5'd0,  32'h0,        '0};
    tbl[7]  = '{'1, '1, '1, '1, '0, 5'd9,  32'h0,        32'h0,        '0, 5'd9,  5'd8,  '1, '0, '0, '1, '0, '0, 5'd0,  32'h0,        '0};
    tbl[8]  = '{'1, '1, '1, '1, '0, 5'd9,  32'h0,        32'h1234,     '1, 5'd9,  5'd8,  '1, '0, '0, '1, '0, '1, 5'd9,  32'h1234,     '0};
    tbl[9]  = '{'1, '1, '1, '1, '0, 5'd3,  32'h0,        32'hAA,       '1, 5'd9,  5'd3,  '1, '1, '0, '0, '0, '1, 5'd3,  32'hAA,       '0};
    tbl[10] = '{'1, '1, '1, '0, '0, 5'd4,  32'hBB,       32'h0,        '0, 5'd4,  5'd4,  '1, '1, '0, '0, '0, '1, 5'd4,  32'hBB,       '0};
    tbl[11] = '{'1, '0, '0, '0, '0, 5'd0,  32'h0,        32'h77,       '1, 5'd0,  5'd0,  '1, '1, '0, '0, '0, '0, 5'd0,  32'h0,        '0};
    tbl[12] = '{'1, '1, '1, '0, '1, 5'd7,  32'h1,        32'h0,        '0, 5'd0,  5'd0,  '1, '1, '0, '0, '0, '1, 5'd7,  32'h1,        '0};
    tbl[13] = '{'1, '1, '1, '0, '0, 5'd6,  32'h66,       32'h0,        '0, 5'd0,  5'd0,  '1, '0, '1, '0, '0, '0, 5'd0,  32'h0,        '0};
    tbl[14] = '{'1, '0, '0, '0, '0, 5'd0,  32'h0,        32'h0,        '0, 5'd0,  5'd0,  '1, '0, '1, '0, '0, '0, 5'd0,  32'h0,        '0};
    tbl[15] = '{'0, '0, '0, '0, '0, 5'd0,  32'h0,        32'h0,        '0, 5'd0,  5'd0,  '1, '0, '1, '0, '0, '0, 5'd0,  32'h0,        '1};
    tbl[16] = '{'1, '1, '1, '1, '0, 5'd2,  32'h0,        32'h0,        '0, 5'd2,  5'd2,  '1, '1, '0, '0, '0, '0, 5'd0,  32'h0,        '0};
    tbl[17] = '{'0, '1, '1, '1, '0, 5'd2,  32'h0,        32'h999,      '1, 5'd2,  5'd2,  '1, '0, '0, '1, '1, '0, 5'd0,  32'h0,        '1};
    tbl[18] = '{'1, '0, '0, '0, '0, 5'd0,  32'h0,        32'h999,      '1, 5'd2,  5'd2,  '1, '1, '0, '0, '0, '0, 5'd0,  32'h0,        '0};

    for (int i = 0; i < int'(NVEC); i++) begin
      v = tbl[i];
      nrst = v.nrst; mem_valid = v.valid; mem_regwrite = v.rw; mem_is_load = v.load;
      mem_halt = v.halt; mem_wsel = v.sel; mem_result = v.result; dmemload = v.dmem;
      dhit = v.dhit; rsel1 = v.r1; rsel2 = v.r2;
      #1;
      if (v.chk_pre) begin
        chk($sformatf("vec%0d wb_ready", i), 32'(wb_ready), 32'(v.e_ready));
        chk($sformatf("vec%0d halted", i), 32'(halted), 32'(v.e_halted));
        chk($sformatf("vec%0d pend_hit1", i), 32'(pend_hit1), 32'(v.e_ph1));
        chk($sformatf("vec%0d pend_hit2", i), 32'(pend_hit2), 32'(v.e_ph2));
      end
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d WEN", i), 32'(WEN), 32'(v.e_wen));
      if (v.e_wen || v.chk_data) begin
        chk($sformatf("vec%0d wsel", i), 32'(wsel), 32'(v.e_wsel));
        chk($sformatf("vec%0d wdat", i), wdat, v.e_wdat);
      end
    end

    // Randomized traffic against the reference model.
    m_init = 0;
    for (int c = 0; c < 3000; c++) begin
      nrst         = (c == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      mem_valid    = ($urandom_range(0, 3) != 0);
      mem_regwrite = ($urandom_range(0, 4) != 0);
      mem_is_load  = $urandom_range(0, 1) != 0;
      mem_halt     = !mem_is_load && ($urandom_range(0, 99) == 0);
      mem_wsel     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      mem_result   = $urandom;
      dmemload     = $urandom;
      dhit         = $urandom_range(0, 2) == 0;
      rsel1        = $urandom_range(0, 1) != 0 ? m_psel : 5'($urandom);
      rsel2        = $urandom_range(0, 1) != 0 ? m_psel : 5'($urandom);
      #1;
      if (m_init) check_model_pre(c);
      @(posedge CLK);
      model_edge();
      #1;
      check_model_post(c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
